// File: rtl/stream_seq_source_if.sv
`default_nettype none
// ============================================================================
// Module      : stream_seq_source_if
// Description : FIFO-read-side stream bundle. The master presents a token on
//               s_dout qualified by s_empty_n; the slave pops it with s_read.
//               The stream word is {eot, payload}, with the EOT flag in the MSB.
// Revision    : 1.0 - initial release
// ============================================================================
interface stream_seq_source_if #(
    parameter int DATA_WIDTH = 32
);
    logic [DATA_WIDTH:0] s_dout;
    logic                s_empty_n;
    logic                s_read;

    modport master (
        output s_dout,
        output s_empty_n,
        input  s_read
    );

    modport slave (
        input  s_dout,
        input  s_empty_n,
        output s_read
    );
endinterface
`default_nettype wire

// File: rtl/stream_seq_source.sv
`default_nettype none
// ============================================================================
// Module      : stream_seq_source
// Description : ap_ctrl_hs-started stream source. It emits n arithmetic
//               tokens (base, base+step, ...), with the payload wrapping
//               modulo 2^DATA_WIDTH, followed by one EOT token {1'b1, 0}.
//               The stream outputs are driven only from registers.
// Revision    : 1.0 - initial release
// ============================================================================
module stream_seq_source #(
    parameter int DATA_WIDTH  = 32,
    parameter int COUNT_WIDTH = 64
) (
    input  wire logic                   ap_clk,
    input  wire logic                   ap_rst_n,
    input  wire logic                   ap_start,
    output logic                        ap_ready,
    output logic                        ap_done,
    output logic                        ap_idle,
    input  wire logic [COUNT_WIDTH-1:0] n,
    input  wire logic [DATA_WIDTH-1:0]  base,
    input  wire logic [DATA_WIDTH-1:0]  step,
    stream_seq_source_if.master         s
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_DATA = 2'd1,
        ST_EOT  = 2'd2
    } state_t;

    localparam logic [COUNT_WIDTH-1:0] C_ONE  = COUNT_WIDTH'(1);
    localparam logic [COUNT_WIDTH-1:0] C_ZERO = '0;

    state_t                  r_state;
    logic [COUNT_WIDTH-1:0]  r_remaining;
    logic [DATA_WIDTH-1:0]   r_step;
    logic [DATA_WIDTH-1:0]   r_payload;
    logic                    r_eot;
    logic                    r_empty_n;
    logic                    r_ready;
    logic                    r_done;
    logic                    r_idle;

    // A pop only counts while a token is actually being presented.
    logic                    w_pop;
    assign w_pop = s.s_read && r_empty_n;

    // Control FSM: handshake, token counter and output token register together.
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            r_state     <= ST_IDLE;
            r_remaining <= C_ZERO;
            r_step      <= '0;
            r_payload   <= '0;
            r_eot       <= 1'b0;
            r_empty_n   <= 1'b0;
            r_ready     <= 1'b0;
            r_done      <= 1'b0;
            r_idle      <= 1'b1;
        end else begin
            r_ready <= 1'b0;
            r_done  <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (ap_start) begin
                        r_remaining <= n;
                        r_step      <= step;
                        r_ready     <= 1'b1;
                        r_idle      <= 1'b0;
                        r_empty_n   <= 1'b1;
                        if (n != C_ZERO) begin
                            r_eot     <= 1'b0;
                            r_payload <= base;
                            r_state   <= ST_DATA;
                        end else begin
                            r_eot     <= 1'b1;
                            r_payload <= '0;
                            r_state   <= ST_EOT;
                        end
                    end
                end
                ST_DATA: begin
                    if (w_pop) begin
                        if (r_remaining == C_ONE) begin
                            r_eot     <= 1'b1;
                            r_payload <= '0;
                            r_state   <= ST_EOT;
                        end else begin
                            r_payload   <= r_payload + r_step;
                            r_remaining <= r_remaining - C_ONE;
                        end
                    end
                end
                ST_EOT: begin
                    if (w_pop) begin
                        r_eot     <= 1'b0;
                        r_payload <= '0;
                        r_empty_n <= 1'b0;
                        r_done    <= 1'b1;
                        r_idle    <= 1'b1;
                        r_state   <= ST_IDLE;
                    end
                end
                default: begin
                    r_empty_n <= 1'b0;
                    r_idle    <= 1'b1;
                    r_state   <= ST_IDLE;
                end
            endcase
        end
    end

    assign s.s_dout    = {r_eot, r_payload};
    assign s.s_empty_n = r_empty_n;
    assign ap_ready    = r_ready;
    assign ap_done     = r_done;
    assign ap_idle     = r_idle;

endmodule
`default_nettype wire

// File: tb/tb_stream_seq_source.sv
`default_nettype none
// ============================================================================
// Module      : tb_stream_seq_source
// Description : Self-checking bench for stream_seq_source. A queue-based model
//               lists every token a transfer must produce; a negedge process
//               compares the DUT each cycle. Literal sequences pin the model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_stream_seq_source;
    localparam int DW = 32;
    localparam int CW = 64;
    localparam logic [DW:0] EOT = {1'b1, {DW{1'b0}}};

    logic          ap_clk   = 1'b0;
    logic          ap_rst_n = 1'b0;
    logic          ap_start = 1'b0;
    logic          ap_ready;
    logic          ap_done;
    logic          ap_idle;
    logic [CW-1:0] n    = '0;
    logic [DW-1:0] base = '0;
    logic [DW-1:0] step = '0;

    stream_seq_source_if #(.DATA_WIDTH(DW)) sif ();

    stream_seq_source #(.DATA_WIDTH(DW), .COUNT_WIDTH(CW)) dut (
        .ap_clk   (ap_clk),
        .ap_rst_n (ap_rst_n),
        .ap_start (ap_start),
        .ap_ready (ap_ready),
        .ap_done  (ap_done),
        .ap_idle  (ap_idle),
        .n        (n),
        .base     (base),
        .step     (step),
        .s        (sif)
    );

    always #5 ap_clk = ~ap_clk;

    int total = 0;
    int bad   = 0;
    int ready_cnt = 0;
    int done_cnt  = 0;
    bit rd_random = 1'b0;

    logic [DW:0] exp_q[$];
    logic [DW:0] popped[$];
    logic [DW:0] lit[$];
    bit m_busy  = 1'b0;
    bit m_ready = 1'b0;
    bit m_done  = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
        end
    endtask

    task automatic chk_seq(input string name, input logic [DW:0] req[$]);
        chk({name, "_len"}, 64'(popped.size()), 64'(req.size()));
        for (int i = 0; i < req.size(); i++) begin
            if (i < popped.size()) chk(name, 64'(popped[i]), 64'(req[i]));
        end
    endtask

    // Per-cycle compare against the model, then advance the model by one edge.
    always @(negedge ap_clk) begin
        if (!ap_rst_n) begin
            chk("rst_empty_n", 64'(sif.s_empty_n), 64'd0);
            chk("rst_dout",    64'(sif.s_dout),    64'd0);
            chk("rst_ready",   64'(ap_ready),      64'd0);
            chk("rst_done",    64'(ap_done),       64'd0);
            chk("rst_idle",    64'(ap_idle),       64'd1);
            exp_q.delete();
            m_busy  = 1'b0;
            m_ready = 1'b0;
            m_done  = 1'b0;
        end else begin
            chk("empty_n", 64'(sif.s_empty_n), 64'(exp_q.size() != 0));
            if (exp_q.size() != 0) chk("dout", 64'(sif.s_dout), 64'(exp_q[0]));
            chk("ap_ready", 64'(ap_ready), 64'(m_ready));
            chk("ap_done",  64'(ap_done),  64'(m_done));
            chk("ap_idle",  64'(ap_idle),  64'(!m_busy));
            if (ap_ready === 1'b1) ready_cnt++;
            if (ap_done === 1'b1)  done_cnt++;
            m_ready = 1'b0;
            m_done  = 1'b0;
            if (!m_busy) begin
                if (ap_start) begin
                    for (int i = 0; i < int'(n); i++) begin
                        logic [DW-1:0] v;
                        v = step * DW'(i);
                        v = v + base;
                        exp_q.push_back({1'b0, v});
                    end
                    exp_q.push_back(EOT);
                    m_busy  = 1'b1;
                    m_ready = 1'b1;
                end
            end else if (sif.s_read && exp_q.size() != 0) begin
                popped.push_back(sif.s_dout);
                void'(exp_q.pop_front());
                if (exp_q.size() == 0) begin
                    m_busy = 1'b0;
                    m_done = 1'b1;
                end
            end
        end
    end

    // Consumer: s_read either held high or toggled at random.
    initial begin
        sif.s_read = 1'b0;
        forever begin
            @(posedge ap_clk);
            #1;
            sif.s_read = rd_random ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    task automatic cyc(input int k);
        repeat (k) @(posedge ap_clk);
        #1;
    endtask

    // One-cycle start pulse; arguments are scrambled afterwards.
    task automatic start(input logic [CW-1:0] tn, input logic [DW-1:0] tb_base, input logic [DW-1:0] tb_step);
        ap_start = 1'b1;
        n    = tn;
        base = tb_base;
        step = tb_step;
        cyc(1);
        ap_start = 1'b0;
        n    = CW'($urandom);
        base = $urandom;
        step = $urandom;
    endtask

    task automatic wait_done(input string name, input int budget);
        int k = 0;
        while (ap_done !== 1'b1 && k < budget) begin
            cyc(1);
            k++;
        end
        chk({name, "_timeout"}, 64'(k < budget), 64'd1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int r;
        int d;
        int k;
        int rc0;
        cyc(3);
        ap_rst_n = 1'b1;
        cyc(2);

        // Basic sequence
        rd_random = 1'b0;
        popped.delete();
        start(64'd5, 32'd0, 32'd1);
        wait_done("basic", 100);
        lit = '{33'd0, 33'd1, 33'd2, 33'd3, 33'd4, EOT};
        chk_seq("basic", lit);
        cyc(1);

        // Backpressure
        rd_random = 1'b1;
        popped.delete();
        start(64'd4, 32'd10, 32'd3);
        wait_done("bp", 200);
        lit = '{33'd10, 33'd13, 33'd16, 33'd19, EOT};
        chk_seq("bp", lit);
        cyc(1);

        // Empty transfer
        popped.delete();
        start(64'd0, 32'd55, 32'd9);
        wait_done("empty", 100);
        lit = '{EOT};
        chk_seq("empty", lit);
        cyc(1);
        chk("empty_idle", 64'(ap_idle), 64'd1);

        // Wrap-around
        popped.delete();
        start(64'd3, 32'hFFFF_FFFE, 32'd1);
        wait_done("wrap", 200);
        lit = '{{1'b0, 32'hFFFF_FFFE}, {1'b0, 32'hFFFF_FFFF}, 33'd0, EOT};
        chk_seq("wrap", lit);
        cyc(2);

        // Back-to-back with held start
        rd_random = 1'b0;
        popped.delete();
        rc0 = ready_cnt;
        ap_start = 1'b1;
        n = 64'd2;
        base = 32'd100;
        step = 32'd5;
        r = 0;
        d = 0;
        k = 0;
        while (r < 2 && k < 100) begin
            cyc(1);
            k++;
            if (ap_ready === 1'b1) r++;
            if (ap_done === 1'b1) d++;
        end
        ap_start = 1'b0;
        while (d < 2 && k < 100) begin
            cyc(1);
            k++;
            if (ap_done === 1'b1) d++;
        end
        chk("b2b_timeout", 64'(k < 100), 64'd1);
        cyc(5);
        chk("b2b_ready_cnt", 64'(ready_cnt - rc0), 64'd2);
        chk("b2b_done_cnt", 64'(d), 64'd2);
        lit = '{33'd100, 33'd105, EOT, 33'd100, 33'd105, EOT};
        chk_seq("b2b", lit);

        // Reset mid-transfer
        popped.delete();
        start(64'd5, 32'd20, 32'd1);
        k = 0;
        while (popped.size() < 2 && k < 50) begin
            cyc(1);
            k++;
        end
        chk("rstmid_timeout", 64'(k < 50), 64'd1);
        #1;
        ap_rst_n = 1'b0;
        #1;
        chk("async_empty_n", 64'(sif.s_empty_n), 64'd0);
        chk("async_dout",    64'(sif.s_dout),    64'd0);
        chk("async_ready",   64'(ap_ready),      64'd0);
        chk("async_done",    64'(ap_done),       64'd0);
        chk("async_idle",    64'(ap_idle),       64'd1);
        cyc(2);
        ap_rst_n = 1'b1;
        cyc(1);
        popped.delete();
        start(64'd3, 32'd7, 32'd2);
        wait_done("after_rst", 100);
        lit = '{33'd7, 33'd9, 33'd11, EOT};
        chk_seq("after_rst", lit);
        cyc(1);

        // Randomized transfers under random backpressure
        rd_random = 1'b1;
        for (int t = 0; t < 20; t++) begin
            start(CW'($urandom_range(0, 8)), $urandom, $urandom);
            wait_done("rand", 400);
            cyc($urandom_range(0, 3));
        end

        cyc(3);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/stream_seq_source.md
# stream_seq_source

Stream transmitter that produces an arithmetic sequence of `n` data tokens followed by one close (EOT) token. The output is a FIFO-read-side stream, so a kernel's stream input port (`*_dout/*_empty_n/*_read`) connects to it directly. It is started and completed through an ap_ctrl_hs handshake. It serves as an RTL stimulus source in stream-top functional tests and as a reusable on-chip test pattern generator.

## Interface
Parameters:
- `DATA_WIDTH`, 32, payload width; stream word is `DATA_WIDTH+1` bits, MSB = EOT flag.
- `COUNT_WIDTH`, 64, width of the token-count argument `n`.

Ports:
- `ap_clk` in 1: single clock; all logic rising-edge.
- `ap_rst_n` in 1: reset, asynchronous assert, active-low.
- `ap_start` in 1: start request (ap_ctrl_hs).
- `ap_ready` out 1: one-cycle pulse when arguments are latched.
- `ap_done` out 1: one-cycle pulse after the EOT token is consumed.
- `ap_idle` out 1: high while no transfer is in progress.
- `n` in COUNT_WIDTH: number of data tokens to send before EOT.
- `base` in DATA_WIDTH: value of the first data token.
- `step` in DATA_WIDTH: increment between consecutive data tokens.
- `s_dout` out DATA_WIDTH+1: current token, `{eot, payload}`.
- `s_empty_n` out 1: high when `s_dout` holds a valid token.
- `s_read` in 1: consumer pops the current token at the rising edge.

## Operation
- States: IDLE, DATA, EOT.
- IDLE: `s_empty_n=0`, `ap_idle=1`. When `ap_start=1` at a rising edge:
  - latch `n` into `remaining`, latch `step`;
  - if `n!=0`, load `s_dout={1'b0, base}` and go to DATA;
  - if `n==0`, load `s_dout={1'b1, 0}` and go to EOT.
- DATA: a pop is `s_read && s_empty_n` at a rising edge.
  - If `remaining==1`, load `{1'b1, 0}` and go to EOT.
  - Otherwise, load `{1'b0, payload+step}` and decrement `remaining`.
  - Payload addition wraps modulo 2^DATA_WIDTH; no saturation.
- EOT: on a pop, go to IDLE and clear `s_empty_n`.
- `s_read` while `s_empty_n=0` is ignored; no state change.
- `ap_start` is ignored outside IDLE.
- Argument ports are sampled only at the accepting edge; later changes have no effect on a running transfer.
- Reset mid-transfer aborts immediately; the pending token is discarded and the block returns to IDLE.

## Timing
- Reset values: `s_empty_n=0`, `s_dout=0`, `ap_ready=0`, `ap_done=0`, `ap_idle=1`.
- `s_dout` and `s_empty_n` come directly from registers, with no combinational path from `s_read`.
- Start-to-first-token latency is 1 cycle: in the cycle after the accepting edge, `s_empty_n=1`, `s_dout` holds the first token, `ap_ready=1` (single cycle), and `ap_idle=0`.
- Throughput is one token per cycle when `s_read` is held high.
- A complete transfer takes `n+1` pops minimum.
- When the EOT pop occurs at edge E:
  - in cycle E+1, `ap_done=1` (single cycle), `ap_idle=1`, `s_empty_n=0`;
  - `ap_start` sampled at edge E+1 starts a new transfer, giving back-to-back operation with one bubble cycle.
- If `ap_start` is still high when `ap_ready` pulses, it does not cause a second start, because the block is no longer in IDLE.
- A held `s_dout` stays stable while `s_empty_n=1 && s_read=0`, for any number of stall cycles.

## Test plan
- **Basic sequence.** Drive `n=5`, `base=0`, `step=1`, with `s_read` held high. Required response: tokens 0,1,2,3,4 with eot=0, then `{1,0}`; `ap_ready` pulses 1 cycle after start; `ap_done` pulses 1 cycle after the EOT pop.
- **Backpressure.** Drive `n=4`, `base=10`, `step=3`, with `s_read` toggled pseudo-randomly. Required response: payload sequence 10,13,16,19, then EOT; `s_dout` is unchanged across every stall cycle; no token is dropped or duplicated.
- **Empty transfer.** Drive `n=0`. Required response: the first and only token is `{1,0}`; `ap_done` pulses after its pop; `ap_idle` returns to 1.
- **Wrap-around.** Drive `DATA_WIDTH=32`, `n=3`, `base=32'hFFFF_FFFE`, `step=1`. Required response: payloads FFFF_FFFE, FFFF_FFFF, 0000_0000, then EOT.
- **Back-to-back and held start.** Hold `ap_start` high across two transfers with `n=2`. Required response: exactly two transfers, separated by one `s_empty_n=0` cycle; two `ap_ready` pulses and two `ap_done` pulses.
- **Reset mid-transfer.** Assert `ap_rst_n=0` asynchronously after 2 pops of an `n=5` transfer. Required response: all outputs take their reset values immediately; the next start with `base=7` begins at 7.
